// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: decoded control inputs in, program counter and run status out.
interface pc_sequencer_if #(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 start;
  logic                 stall;
  logic                 halt_req;
  logic                 jump_en;
  logic [PC_WIDTH-1:0]  jump_target;
  logic                 branch_en;
  logic                 zero;
  logic [7:0]           branch_offset;
  logic [PC_WIDTH-1:0]  pc;
  logic                 running;
  logic                 done;
  logic                 branch_taken;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    output start, stall, halt_req, jump_en, jump_target, branch_en, zero, branch_offset,
    input  pc, running, done, branch_taken, retired
  );

  modport slave (
    input  start, stall, halt_req, jump_en, jump_target, branch_en, zero, branch_offset,
    output pc, running, done, branch_taken, retired
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control, jump/BEQ target
// selection and a saturating retired-instruction counter.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH   = 10,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic            clk,
  input  logic            reset,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

  state_t                state;
  state_t                state_next;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic [CNT_WIDTH-1:0]  retired_next;
  logic [CNT_WIDTH-1:0]  retired_inc;
  logic                  branch_taken_q;
  logic                  branch_taken_next;
  logic                  running_q;
  logic                  done_q;
  logic [PC_WIDTH-1:0]   offset_ext;

  // Offset is two's complement; the add wraps modulo 2^PC_WIDTH.
  assign offset_ext  = PC_WIDTH'($signed(bus.branch_offset));
  assign retired_inc = (retired_q == {CNT_WIDTH{1'b1}}) ? retired_q
                                                        : retired_q + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next        = state;
    pc_next           = pc_q;
    retired_next      = retired_q;
    branch_taken_next = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_next   = RUN;
          pc_next      = START_PC;
          retired_next = '0;
        end
      end
      RUN: begin
        // A HALT retires even when the pipe is stalled.
        if (bus.halt_req) begin
          state_next   = HALTED;
          retired_next = retired_inc;
        end else if (bus.stall) begin
          pc_next      = pc_q;
        end else if (bus.jump_en) begin
          pc_next      = bus.jump_target;
          retired_next = retired_inc;
        end else if (bus.branch_en && bus.zero) begin
          pc_next           = pc_q + offset_ext;
          branch_taken_next = 1'b1;
          retired_next      = retired_inc;
        end else begin
          pc_next      = pc_q + PC_WIDTH'(1);
          retired_next = retired_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status flags are registered alongside the state so they track it exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= START_PC;
      retired_q      <= '0;
      branch_taken_q <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      pc_q           <= pc_next;
      retired_q      <= retired_next;
      branch_taken_q <= branch_taken_next;
      running_q      <= (state_next == RUN);
      done_q         <= (state_next == HALTED);
    end
  end

  assign bus.pc           = pc_q;
  assign bus.retired      = retired_q;
  assign bus.branch_taken = branch_taken_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer, plus a narrow-counter copy for saturation.
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.PC_WIDTH(10), .CNT_WIDTH(16)) bus ();
  pc_sequencer_if #(.PC_WIDTH(10), .CNT_WIDTH(4))  sbus ();

  pc_sequencer #(.PC_WIDTH(10), .START_ADDR(0), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_sequencer #(.PC_WIDTH(10), .START_ADDR(0), .CNT_WIDTH(4)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  assign sbus.start         = bus.start;
  assign sbus.stall         = bus.stall;
  assign sbus.halt_req      = bus.halt_req;
  assign sbus.jump_en       = bus.jump_en;
  assign sbus.jump_target   = bus.jump_target;
  assign sbus.branch_en     = bus.branch_en;
  assign sbus.zero          = bus.zero;
  assign sbus.branch_offset = bus.branch_offset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic [31:0] eret,
                           input logic erun, input logic edone, input logic ebt);
    check({tag, ".pc"},           32'(bus.pc),           epc);
    check({tag, ".retired"},      32'(bus.retired),      eret);
    check({tag, ".running"},      32'(bus.running),      32'(erun));
    check({tag, ".done"},         32'(bus.done),         32'(edone));
    check({tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(ebt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.stall = 1'b0; bus.halt_req = 1'b0;
    bus.jump_en = 1'b0; bus.jump_target = '0;
    bus.branch_en = 1'b0; bus.zero = 1'b0; bus.branch_offset = '0;
    step(); step();
    check_all("reset", 32'h0, 0, 1'b0, 1'b0, 1'b0);

    reset = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_all("start", 32'h0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("seq%0d.pc", i), 32'(bus.pc), 32'(i));
    end
    check_all("seq_end", 32'h5, 5, 1'b1, 1'b0, 1'b0);
    check("sat.early", 32'(sbus.retired), 32'd5);

    bus.jump_en = 1'b1; bus.jump_target = 10'h010;
    step();
    bus.jump_en = 1'b0;
    check_all("jump010", 32'h010, 6, 1'b1, 1'b0, 1'b0);

    bus.branch_en = 1'b1; bus.zero = 1'b1; bus.branch_offset = 8'hFC;
    step();
    check_all("beq_back", 32'h00C, 7, 1'b1, 1'b0, 1'b1);
    bus.branch_en = 1'b0; bus.zero = 1'b0;
    step();
    check_all("bt_pulse_end", 32'h00D, 8, 1'b1, 1'b0, 1'b0);

    bus.jump_en = 1'b1; bus.jump_target = 10'h010;
    step();
    bus.jump_en = 1'b0;
    bus.branch_en = 1'b1; bus.zero = 1'b0; bus.branch_offset = 8'hFC;
    step();
    bus.branch_en = 1'b0;
    check_all("beq_not_taken", 32'h011, 10, 1'b1, 1'b0, 1'b0);

    bus.jump_en = 1'b1; bus.jump_target = 10'h3FF;
    step();
    bus.jump_en = 1'b0;
    check_all("jump3ff", 32'h3FF, 11, 1'b1, 1'b0, 1'b0);
    step();
    check_all("inc_wrap", 32'h000, 12, 1'b1, 1'b0, 1'b0);

    bus.branch_en = 1'b1; bus.zero = 1'b1; bus.branch_offset = 8'hFF;
    step();
    check_all("beq_back_wrap", 32'h3FF, 13, 1'b1, 1'b0, 1'b1);
    bus.branch_offset = 8'h01;
    step();
    check_all("beq_fwd_wrap", 32'h000, 14, 1'b1, 1'b0, 1'b1);
    bus.branch_en = 1'b0; bus.zero = 1'b0;
    step();
    check_all("plain_after_beq", 32'h001, 15, 1'b1, 1'b0, 1'b0);
    check("sat.max", 32'(sbus.retired), 32'd15);

    bus.stall = 1'b1; bus.branch_en = 1'b1; bus.zero = 1'b1; bus.branch_offset = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all($sformatf("stall%0d", i), 32'h001, 15, 1'b1, 1'b0, 1'b0);
    end
    bus.halt_req = 1'b1;
    step();
    bus.halt_req = 1'b0; bus.stall = 1'b0;
    check_all("halt_in_stall", 32'h001, 16, 1'b0, 1'b1, 1'b0);
    check("sat.hold", 32'(sbus.retired), 32'd15);

    bus.jump_en = 1'b1; bus.jump_target = 10'h200;
    step();
    check_all("halted_a", 32'h001, 16, 1'b0, 1'b1, 1'b0);
    bus.jump_en = 1'b0; bus.zero = 1'b0;
    step();
    check_all("halted_b", 32'h001, 16, 1'b0, 1'b1, 1'b0);
    bus.branch_en = 1'b0;

    bus.start = 1'b1;
    step();
    check_all("restart", 32'h000, 0, 1'b1, 1'b0, 1'b0);
    step();
    bus.start = 1'b0;
    check_all("start_in_run", 32'h001, 1, 1'b1, 1'b0, 1'b0);

    bus.jump_en = 1'b1; bus.jump_target = 10'h123;
    step();
    check_all("jump123", 32'h123, 2, 1'b1, 1'b0, 1'b0);
    reset = 1'b1; bus.start = 1'b1;
    step();
    check_all("mid_reset", 32'h000, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0; bus.start = 1'b0;
    step();
    bus.jump_en = 1'b0;
    check_all("idle_ignores", 32'h000, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
